// File: rtl/spi_pkg.sv
// ============================================================================
//  Module   : spi_pkg
//  Brief    : Shared types and constants for the SPI byte engine
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

  // Engine states, explicitly 3 bits wide
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

  // Default clk cycles per SPI clock half-period
  localparam int unsigned c_clk_div_default = 4;
  // Default minimum clk cycles of CS high between transactions
  localparam int unsigned c_cs_gap_default  = 8;
  // Width of the bit counter within a byte
  localparam int unsigned c_bit_cnt_w       = 3;

endpackage

`default_nettype wire

// File: rtl/spi_clk_tick.sv
// ============================================================================
//  Module   : spi_clk_tick
//  Brief    : Half-period counter; one-cycle tick every CLK_DIV enabled cycles
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_clk_tick
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = c_clk_div_default
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] c_cnt_last = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;

  assign tick = en && (r_cnt == c_cnt_last);

  // Count while enabled, wrap on tick, hold at zero while disabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!en || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_byte_engine.sv
// ============================================================================
//  Module   : spi_byte_engine
//  Brief    : Byte-oriented SPI mode-0 master with CS hold and inter-frame gap
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_byte_engine
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = c_clk_div_default,
  parameter int unsigned CS_GAP  = c_cs_gap_default
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       busy,
  output logic       spi_csb,
  output logic       spi_clk,
  output logic       spi_do,
  input  logic       spi_di
);

  localparam logic [7:0]             c_gap_last = 8'(CS_GAP - 1);
  localparam logic [c_bit_cnt_w-1:0] c_bit_last = '1;

  spi_state_e             r_state;
  spi_state_e             w_state_nxt;
  logic                   w_tick;
  logic                   w_hs;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_done;
  logic                   w_ready_nxt;
  logic                   w_csb_nxt;
  logic                   w_sclk_nxt;
  logic                   w_do_nxt;
  logic [6:0]             r_tx_sh;
  logic [7:0]             r_rx_sh;
  logic [7:0]             r_rx_byte;
  logic [7:0]             r_gap_cnt;
  logic [c_bit_cnt_w-1:0] r_bit_cnt;
  logic                   r_last;
  logic                   r_rx_valid;
  logic                   r_tx_ready;
  logic                   r_csb;
  logic                   r_sclk;
  logic                   r_do;

  // Half-period timer also times the CS hold after the last byte
  spi_clk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    ((r_state == SHIFT) || (r_state == HOLD)),
    .tick  (w_tick)
  );

  assign w_hs   = tx_valid && r_tx_ready;
  assign w_rise = (r_state == SHIFT) && w_tick && !r_sclk;
  assign w_fall = (r_state == SHIFT) && w_tick && r_sclk;
  assign w_done = w_fall && (r_bit_cnt == c_bit_last);

  assign tx_ready = r_tx_ready;
  assign rx_byte  = r_rx_byte;
  assign rx_valid = r_rx_valid;
  assign spi_csb  = r_csb;
  assign spi_clk  = r_sclk;
  assign spi_do   = r_do;
  assign busy     = (r_state != IDLE);

  // State register and registered bus/handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_tx_ready <= 1'b0;
      r_csb      <= 1'b1;
      r_sclk     <= 1'b0;
      r_do       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_ready <= w_ready_nxt;
      r_csb      <= w_csb_nxt;
      r_sclk     <= w_sclk_nxt;
      r_do       <= w_do_nxt;
    end
  end

  // Next-state decision
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_state_nxt = SHIFT;
      SHIFT:   if (w_done) w_state_nxt = r_last ? HOLD : WAIT;
      WAIT:    if (w_hs) w_state_nxt = SHIFT;
      HOLD:    if (w_tick) w_state_nxt = GAP;
      GAP:     if (r_gap_cnt == c_gap_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the next state
  always_comb begin
    w_ready_nxt = (w_state_nxt == IDLE) || (w_state_nxt == WAIT);
    w_csb_nxt   = (w_state_nxt == IDLE) || (w_state_nxt == GAP);
    w_sclk_nxt  = r_sclk;
    if (w_rise) w_sclk_nxt = 1'b1;
    if (w_fall) w_sclk_nxt = 1'b0;
    w_do_nxt = r_do;
    if (w_hs) begin
      w_do_nxt = tx_byte[7];
    end else if (w_fall && !w_done) begin
      w_do_nxt = r_tx_sh[6];
    end
    // Data line is parked low whenever the flash is deselected
    if (w_csb_nxt) w_do_nxt = 1'b0;
  end

  // Shift registers, bit/gap counters and receive pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_byte  <= '0;
      r_gap_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_last     <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      if (w_hs) begin
        r_tx_sh   <= tx_byte[6:0];
        r_last    <= tx_last;
        r_bit_cnt <= '0;
      end else if (w_fall) begin
        r_tx_sh   <= {r_tx_sh[5:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_rise) r_rx_sh <= {r_rx_sh[6:0], spi_di};
      r_rx_valid <= w_done;
      if (w_done) r_rx_byte <= r_rx_sh;
      if (r_state == GAP) r_gap_cnt <= r_gap_cnt + 1'b1;
      else                r_gap_cnt <= '0;
    end
  end

endmodule

`default_nettype wire
